// File: rtl/cpu_pkg.sv
// Shared CPU constants and the fetch buffer entry type.
// Imported by the fetch stage and its buffer.
package cpu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode valid/ready bundle.
// Fetch drives the head entry; decode drives out_ready.
interface fetch_unit_if;
  logic                     out_valid;
  logic                     out_ready;
  logic [cpu_pkg::XLEN-1:0] out_instr;
  logic [cpu_pkg::XLEN-1:0] out_pc;
  logic [cpu_pkg::XLEN-1:0] out_pc_plus4;

  modport master (
    output out_valid,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    output out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small circular buffer of {pc, instr} entries.
// Flush and reset clear every slot and both pointers.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wrEntry,
  output logic [CW-1:0] count,
  output logic         headValid,
  output fetch_entry_t head
);

  fetch_entry_t      mem [DEPTH];
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;

  function automatic logic [PW-1:0] nextPtr(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // When full, wrPtr equals rdPtr, so a push+pop
  // overwrites the slot that is leaving.
  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= wrEntry;
        wrPtr      <= nextPtr(wrPtr);
      end
      if (pop) begin
        rdPtr <= nextPtr(rdPtr);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign headValid = (count != '0);
  assign head      = headValid ? mem[rdPtr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC register, redirect handling and
// fetch counter in front of a small fetch buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  output logic [cpu_pkg::XLEN-1:0] imem_addr,
  input  logic [cpu_pkg::XLEN-1:0] imem_data,
  input  logic                     redirect_valid,
  input  logic [cpu_pkg::XLEN-1:0] redirect_pc,
  fetch_unit_if.master             dec,
  output logic [cpu_pkg::XLEN-1:0] fetch_count
);
  import cpu_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic            headValid;
  logic            push;
  logic            pop;
  fetch_entry_t    head;
  fetch_entry_t    wrEntry;

  assign imem_addr = pc;
  assign pop       = dec.out_valid && dec.out_ready;
  assign push      = !redirect_valid &&
                     ((count < CW'(DEPTH)) || pop);
  assign wrEntry   = '{pc: pc, instr: imem_data};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc          <= RESET_PC;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      pc <= {redirect_pc[XLEN-1:2], 2'b00};
    end else if (push) begin
      pc          <= pc + PC_INC;
      fetch_count <= fetch_count + 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .wrEntry   (wrEntry),
    .count     (count),
    .headValid (headValid),
    .head      (head)
  );

  assign dec.out_valid    = headValid;
  assign dec.out_instr    = head.instr;
  assign dec.out_pc       = head.pc;
  assign dec.out_pc_plus4 = headValid ? head.pc + PC_INC : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] fetch_count;

  fetch_unit_if dec();

  assign imem_data = imem_addr >> 2;

  fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .dec            (dec),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  fetch_entry_t q[$];
  logic [31:0]  mPc = '0;
  logic [31:0]  mCnt = '0;

  task automatic check(string tag,
                       logic [31:0] got,
                       logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic modelStep();
    bit popNow;
    bit pushNow;
    int sz;
    fetch_entry_t e;
    if (!reset_n) begin
      mPc  = 32'h0;
      mCnt = 32'h0;
      q.delete();
    end else if (redirect_valid) begin
      q.delete();
      mPc = {redirect_pc[31:2], 2'b00};
    end else begin
      sz      = q.size();
      popNow  = (sz > 0) && dec.out_ready;
      pushNow = (sz < 2) || popNow;
      if (popNow) void'(q.pop_front());
      if (pushNow) begin
        e.pc    = mPc;
        e.instr = mPc >> 2;
        q.push_back(e);
        mPc  = mPc + 32'd4;
        mCnt = mCnt + 32'd1;
      end
    end
  endtask

  task automatic checkAll();
    check("imem_addr", imem_addr, mPc);
    check("fetch_count", fetch_count, mCnt);
    check("out_valid", 32'(dec.out_valid),
          32'(q.size() != 0));
    if (q.size() != 0) begin
      check("out_pc", dec.out_pc, q[0].pc);
      check("out_instr", dec.out_instr, q[0].instr);
      check("out_pc_plus4", dec.out_pc_plus4,
            q[0].pc + 32'd4);
    end else begin
      check("out_pc_empty", dec.out_pc, 32'h0);
      check("out_instr_empty", dec.out_instr, 32'h0);
      check("out_pc_plus4_empty", dec.out_pc_plus4, 32'h0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    dec.out_ready = 1'b0;

    // reset, then stream one per cycle
    reset_n = 1'b0;
    repeat (2) cycle();
    check("rst_valid", 32'(dec.out_valid), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    reset_n = 1'b1;
    dec.out_ready = 1'b1;
    cycle();
    check("first_pc", dec.out_pc, 32'h0);
    repeat (6) cycle();

    // stall with full buffer
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    dec.out_ready = 1'b0;
    repeat (5) cycle();
    check("stall_addr", imem_addr, 32'h8);
    check("stall_cnt", fetch_count, 32'h2);
    check("stall_head", dec.out_pc, 32'h0);

    // redirect with full buffer
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    cycle();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(dec.out_valid), 32'h0);
    check("redir_addr", imem_addr, 32'h100);
    cycle();
    check("redir_pc", dec.out_pc, 32'h100);
    repeat (2) cycle();

    // pop coincident with redirect
    dec.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    cycle();
    dec.out_ready = 1'b0;
    redirect_valid = 1'b0;
    check("poprd_valid", 32'(dec.out_valid), 32'h0);
    check("poprd_addr", imem_addr, 32'h200);

    // address wrap
    dec.out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    check("wrap_pc", dec.out_pc, 32'hFFFF_FFFC);
    check("wrap_p4", dec.out_pc_plus4, 32'h0);
    cycle();
    check("wrap_next", dec.out_pc, 32'h0);

    // reset while full
    dec.out_ready = 1'b0;
    repeat (3) cycle();
    reset_n = 1'b0;
    cycle();
    reset_n = 1'b1;
    check("midrst_valid", 32'(dec.out_valid), 32'h0);
    check("midrst_addr", imem_addr, 32'h0);
    check("midrst_cnt", fetch_count, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(99) >= 2);
      dec.out_ready = ($urandom_range(99) < 60);
      redirect_valid = ($urandom_range(99) < 10);
      if ($urandom_range(3) == 0)
        redirect_pc = 32'hFFFF_FFF0 |
                      32'($urandom_range(15));
      else
        redirect_pc = $urandom;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed",
             nTests, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter DEPTH, default 2, number of entries in the fetch buffer (fixed at 2 for this revision).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 imem_addr  output  32  instruction address presented to the combinational-read instruction memory.
REQ-006 imem_data  input  32  instruction word returned by memory in the same cycle for imem_addr.
REQ-007 redirect_valid  input  1  branch/jump/jr target from a later stage is valid this cycle.
REQ-008 redirect_pc  input  32  target PC accompanying redirect_valid.
REQ-009 out_valid  output  1  buffer head holds a valid instruction for the decode stage.
REQ-010 out_ready  input  1  decode stage accepts the head this cycle; low means stall.
REQ-011 out_instr  output  32  instruction word at the buffer head.
REQ-012 out_pc  output  32  address of out_instr.
REQ-013 out_pc_plus4  output  32  out_pc + 4, modulo 2^32.
REQ-014 fetch_count  output  32  count of instructions pushed into the buffer since reset.

Function
REQ-015 The unit SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally.
REQ-016 pop SHALL be defined as out_valid && out_ready.
REQ-017 push SHALL be defined as !redirect_valid && (count < DEPTH || pop).
REQ-018 On push, the unit SHALL write {PC, imem_data} to the buffer tail and set PC <= PC + 4, with wrap-around from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-019 Without push or redirect, PC SHALL hold its value.
REQ-020 On pop, the head entry SHALL be removed.
REQ-021 count SHALL update to count + push - pop within 0..DEPTH.
REQ-022 Push and pop in the same cycle with count == DEPTH SHALL leave count at DEPTH, with the new entry at the tail.
REQ-023 out_valid SHALL be (count != 0); out_instr, out_pc and out_pc_plus4 SHALL reflect the head entry and be 0 when the buffer is empty.
REQ-024 Latency: an instruction fetched in cycle N SHALL appear at out_* in cycle N+1 when the buffer was empty.
REQ-025 When redirect_valid is high, the unit SHALL discard all buffer entries, including any entry being popped, and set count <= 0.
REQ-026 When redirect_valid is high, the unit SHALL set PC <= {redirect_pc[31:2], 2'b00} and suppress the push for that cycle.
REQ-027 redirect_valid SHALL take priority over push, pop and out_ready; a pop coincident with a redirect still counts as consumed by decode.
REQ-028 fetch_count SHALL increment by 1 on every push and wrap from 32'hFFFF_FFFF to 0.
REQ-029 With out_ready held low and no redirect, the unit SHALL fill the buffer in DEPTH cycles and then hold PC, the buffer contents and fetch_count stable.

Reset
REQ-030 While reset_n is low at a rising edge, the unit SHALL set PC <= RESET_PC, count <= 0, fetch_count <= 0 and clear all buffer entries.
REQ-031 Reset SHALL take priority over redirect_valid, push and pop.
REQ-032 In the first cycle after reset deasserts, imem_addr SHALL equal RESET_PC and out_valid SHALL be 0.
REQ-033 Reset asserted mid-stall SHALL discard buffered instructions without presenting them.

Structure
REQ-034 The shared package cpu_pkg SHALL hold RESET_PC, the instruction/address width constant (32) and the PC increment constant (4).
REQ-035 The buffer SHALL be a sub-module named fetch_fifo: DEPTH entries of {pc, instr}, with push, pop, flush, count and head outputs.
REQ-036 fetch_unit SHALL contain only the PC register, the push/redirect logic and fetch_count.

Verification
REQ-037 Reset, then out_ready=1 with memory word[i]=i: out_pc SHALL read 0,4,8,... one per cycle starting the cycle after reset, and out_instr SHALL equal the matching word index.
REQ-038 out_ready=0 for 5 cycles: the buffer SHALL hold PC 0 and 4, imem_addr SHALL stay at 8, and fetch_count SHALL stay at 2.
REQ-039 With a full buffer, pulse redirect_valid with redirect_pc=32'h0000_0103: out_valid SHALL be 0 the next cycle, imem_addr SHALL be 32'h0000_0100, and the following cycle out_pc SHALL be 32'h0000_0100.
REQ-040 With a full buffer, pulse out_ready and redirect_valid in the same cycle: the buffer SHALL be empty the next cycle and PC SHALL equal the redirect target.
REQ-041 Redirect to 32'hFFFF_FFFC with out_ready=1: out_pc SHALL read 32'hFFFF_FFFC then 0, with out_pc_plus4 = 0 for the first.
REQ-042 Assert reset_n=0 while the buffer is full: the next cycle out_valid SHALL be 0, imem_addr SHALL be RESET_PC and fetch_count SHALL be 0.
